// File: rtl/serial_pattern_scan_ctrl.sv
// -----------------------------------------------------------------------------
// serial_pattern_scan_ctrl
//
// Purpose:
//   Accepts a WIDTH-bit word on a valid/ready handshake and shifts it LSB-first
//   into an embedded Mealy "0011" detector, one bit per clock. It counts the
//   detections and then returns the count on a second valid/ready handshake.
//
// Configuration macro:
//   FRAME_CLEAR_EN  defined     : detector is forced to D0 when a word is accepted,
//                                 so patterns never straddle word boundaries.
//                   not defined : detector state carries over between words; a
//                                 straddling pattern counts in the later word.
//
// Ports:
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous reset, active-high
//   in_valid   in   1      producer presents a word on in_data
//   in_ready   out  1      controller can accept a word (IDLE)
//   in_data    in   WIDTH  word to scan, bit 0 presented first
//   bit_out    out  1      bit currently presented to the detector
//   bit_valid  out  1      bit_out is valid this cycle (SHIFT)
//   hit        out  1      "0011" completes on bit_out this cycle
//   out_valid  out  1      hit_count holds a finished result (REPORT)
//   out_ready  in   1      consumer accepts the result
//   hit_count  out  CNT_W  detections in the last scanned word
//   busy       out  1      high in SHIFT or REPORT
// -----------------------------------------------------------------------------
module serial_pattern_scan_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH / 4 + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             hit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] hit_count,
  output logic             busy
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    C_IDLE   = 2'd0,
    C_SHIFT  = 2'd1,
    C_REPORT = 2'd2
  } ctrl_e;

  // Dn means "the last n bits form the first n bits of 0011".
  typedef enum logic [1:0] {
    D0 = 2'd0,
    D1 = 2'd1,
    D2 = 2'd2,
    D3 = 2'd3
  } det_e;

  ctrl_e            ctrl_r;
  ctrl_e            ctrl_s;
  det_e             det_r;
  det_e             det_s;
  logic [WIDTH-1:0] word_r;
  logic [IDX_W-1:0] idx_r;
  logic [CNT_W-1:0] count_r;
  logic             accept_s;

  // Detector transition for one presented bit.
  function automatic det_e det_next(input det_e s, input logic b);
    det_e n;
    case (s)
      D0:      n = b ? D0 : D1;
      D1:      n = b ? D0 : D2;
      D2:      n = b ? D3 : D2;
      D3:      n = b ? D0 : D1;  // a 0 after "001" is itself a fresh leading 0
      default: n = D0;
    endcase
    return n;
  endfunction

  // Mealy output: the presented bit completes "0011".
  function automatic logic det_hit(input det_e s, input logic b);
    return (s == D3) && b;
  endfunction

  // Handshake-facing outputs decoded from the controller state register.
  always_comb begin
    in_ready  = (ctrl_r == C_IDLE);
    bit_valid = (ctrl_r == C_SHIFT);
    out_valid = (ctrl_r == C_REPORT);
    busy      = (ctrl_r == C_SHIFT) || (ctrl_r == C_REPORT);
    hit_count = count_r;
    accept_s  = in_valid && (ctrl_r == C_IDLE);
    if (ctrl_r == C_SHIFT) begin
      bit_out = word_r[idx_r];
      hit     = det_hit(det_r, word_r[idx_r]);
    end else begin
      bit_out = 1'b0;
      hit     = 1'b0;
    end
  end

  // Controller next-state logic.
  always_comb begin
    ctrl_s = ctrl_r;
    case (ctrl_r)
      C_IDLE: begin
        if (in_valid) begin
          ctrl_s = C_SHIFT;
        end else begin
          ctrl_s = C_IDLE;
        end
      end
      C_SHIFT: begin
        if (idx_r == IDX_W'(WIDTH - 1)) begin
          ctrl_s = C_REPORT;
        end else begin
          ctrl_s = C_SHIFT;
        end
      end
      C_REPORT: begin
        if (out_ready) begin
          ctrl_s = C_IDLE;
        end else begin
          ctrl_s = C_REPORT;
        end
      end
      default: ctrl_s = C_IDLE;
    endcase
  end

  // Detector next-state: advances only on presented bits, optionally cleared per word.
  always_comb begin
    det_s = det_r;
    if (accept_s) begin
`ifdef FRAME_CLEAR_EN
      det_s = D0;
`else
      det_s = det_r;
`endif
    end else if (ctrl_r == C_SHIFT) begin
      det_s = det_next(det_r, word_r[idx_r]);
    end else begin
      det_s = det_r;
    end
  end

  // State, word buffer, bit index and hit counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_r  <= C_IDLE;
      det_r   <= D0;
      word_r  <= '0;
      idx_r   <= '0;
      count_r <= '0;
    end else begin
      ctrl_r <= ctrl_s;
      det_r  <= det_s;
      if (accept_s) begin
        word_r  <= in_data;
        idx_r   <= '0;
        count_r <= '0;
      end else if (ctrl_r == C_SHIFT) begin
        idx_r <= idx_r + IDX_W'(1);
        if (hit) begin
          count_r <= count_r + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_pattern_scan_ctrl.sv
// Scoreboard bench: accepted words are run through a reference model that looks
// for "0011" in the recent bit history; a negedge monitor pops expected bits,
// hits and counts as the DUT presents them.
module tb_serial_pattern_scan_ctrl;

  localparam int WIDTH = 8;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             bit_out;
  logic             bit_valid;
  logic             hit;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] hit_count;
  logic             busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit mon_en = 1'b1;

  bit         hist[$];
  logic [1:0] exp_bit_q[$];   // {bit, hit}
  int         exp_cnt_q[$];
  int         acc_times[$];

  serial_pattern_scan_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .bit_out(bit_out), .bit_valid(bit_valid), .hit(hit),
    .out_valid(out_valid), .out_ready(out_ready), .hit_count(hit_count),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Reference: a hit is whenever the four most recent bits are 0,0,1,1 in order.
  task automatic model_push(input logic [WIDTH-1:0] w);
    int   cnt;
    logic h;
    cnt = 0;
`ifdef FRAME_CLEAR_EN
    hist.delete();
`endif
    for (int i = 0; i < WIDTH; i++) begin
      hist.push_back(w[i]);
      if (hist.size() > 4) void'(hist.pop_front());
      h = (hist.size() == 4) && (hist[0] == 1'b0) && (hist[1] == 1'b0) &&
          (hist[2] == 1'b1) && (hist[3] == 1'b1);
      if (h) cnt++;
      exp_bit_q.push_back({w[i], h});
    end
    exp_cnt_q.push_back(cnt);
  endtask

  task automatic model_flush();
    hist.delete();
    exp_bit_q.delete();
    exp_cnt_q.delete();
  endtask

  // Acceptance watcher and output monitor.
  always @(negedge clk) begin
    logic [1:0] e;
    if (!rst && in_valid && in_ready) begin
      model_push(in_data);
      acc_times.push_back(cyc);
    end
    if (mon_en && !rst) begin
      if (bit_valid) begin
        if (exp_bit_q.size() == 0) begin
          check("unexpected_bit", 32'd1, 32'd0);
        end else begin
          e = exp_bit_q.pop_front();
          check("bit_out", bit_out, e[1]);
          check("hit", hit, e[0]);
        end
      end else begin
        check("hit_outside_shift", hit, 32'd0);
      end
      if (out_valid && out_ready) begin
        if (exp_cnt_q.size() == 0) begin
          check("unexpected_result", 32'd1, 32'd0);
        end else begin
          check("hit_count", hit_count, exp_cnt_q.pop_front());
        end
      end
    end
  end

  task automatic send_word(input logic [WIDTH-1:0] w);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = w;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_data  = WIDTH'($urandom);
    if (!ok) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic recv(input bit rnd);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rnd) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = WIDTH'($urandom);
      end
      @(negedge clk);
      if (out_valid && out_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    if (!done) check("recv_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int k;
    bit seen_valid;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_in_ready", in_ready, 32'd1);
    check("rst_bit_valid", bit_valid, 32'd0);
    check("rst_bit_out", bit_out, 32'd0);
    check("rst_hit", hit, 32'd0);
    check("rst_out_valid", out_valid, 32'd0);
    check("rst_hit_count", hit_count, 32'd0);
    check("rst_busy", busy, 32'd0);

    // Directed words, including a pattern straddling 00 -> FF
    send_word(8'hCC); recv(1'b0);
    send_word(8'h33); recv(1'b0);
    send_word(8'h00); recv(1'b0);
    send_word(8'h00); recv(1'b0);
    send_word(8'hFF); recv(1'b0);

    // Back-pressure in REPORT with in_valid held high
    send_word(8'hA5);
    k = 0;
    while (!out_valid && k < 50) begin @(posedge clk); #1; k++; end
    check("t4_reach_report", out_valid, 32'd1);
    check("t4_busy", busy, 32'd1);
    in_valid = 1'b1; in_data = 8'h0F; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_out_valid_held", out_valid, 32'd1);
      check("t4_count_stable", hit_count,
            (exp_cnt_q.size() > 0) ? 32'(exp_cnt_q[0]) : 32'hDEAD);
      check("t4_in_ready_low", in_ready, 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("t4_back_idle", in_ready, 32'd1);
    check("t4_out_valid_drop", out_valid, 32'd0);

    // Reset in the third SHIFT cycle
    mon_en = 1'b0;
    send_word(8'hCC);
    @(posedge clk); #1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b0;
    model_flush();
    check("t5_in_ready", in_ready, 32'd1);
    check("t5_bit_valid", bit_valid, 32'd0);
    check("t5_out_valid", out_valid, 32'd0);
    check("t5_hit_count", hit_count, 32'd0);
    check("t5_busy", busy, 32'd0);
    seen_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid || bit_valid) seen_valid = 1'b1;
    end
    check("t5_no_result", seen_valid, 32'd0);
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Back-to-back words with in_valid and out_ready held high
    acc_times.delete();
    in_data = 8'h3C; in_valid = 1'b1; out_ready = 1'b1;
    k = 0;
    while (acc_times.size() < 2 && k < 60) begin @(posedge clk); k++; end
    #1 in_valid = 1'b0;
    check("t6_two_accepts", acc_times.size(), 32'd2);
    if (acc_times.size() >= 2)
      check("t6_period", acc_times[1] - acc_times[0], WIDTH + 2);
    k = 0;
    while (exp_cnt_q.size() > 0 && k < 60) begin @(posedge clk); #1; k++; end
    out_ready = 1'b0;
    check("t6_drained", exp_cnt_q.size(), 32'd0);

    // Randomised words with random gaps and back-pressure
    for (int n = 0; n < 40; n++) begin
      send_word(WIDTH'($urandom));
      recv(1'b1);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (3) @(posedge clk);
    #1;
    check("end_cnt_queue_empty", exp_cnt_q.size(), 32'd0);
    check("end_bit_queue_empty", exp_bit_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
